// File: rtl/sgdmac_pkg.sv
// ============================================================================
// sgdmac_pkg
//   Shared types and constants for the scatter-gather DMA descriptor scheduler.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package sgdmac_pkg;

    localparam int SG_ADDR_W  = 32;
    localparam int SG_LEN_W   = 16;

    localparam int DESC_SRC   = 0;
    localparam int DESC_DST   = 1;
    localparam int DESC_LEN   = 2;
    localparam int DESC_NXT   = 3;
    localparam int DESC_WORDS = 4;
    localparam int LAST_BIT   = 0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_REQ  = 3'd1,
        ST_FETCH_WAIT = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_WAIT_XFER  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [SG_ADDR_W-1:0] src;
        logic [SG_ADDR_W-1:0] dst;
        logic [SG_LEN_W-1:0]  len;
        logic [SG_ADDR_W-1:0] next;
        logic                 last;
    } sg_desc_t;

endpackage

`default_nettype wire

// File: rtl/sgdmac_desc_fetch.sv
// ============================================================================
// sgdmac_desc_fetch
//   Reads the four words of one descriptor, one outstanding read at a time.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sgdmac_desc_fetch
    import sgdmac_pkg::*;
#(
    parameter int ADDR_W = SG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_fetch_go,
    input  logic [ADDR_W-1:0] i_fetch_ptr,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_gnt,
    input  logic              i_rd_rvalid,
    input  logic [ADDR_W-1:0] i_rd_rdata,
    output logic              o_desc_valid,
    output sg_desc_t          o_desc
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [1:0]        r_idx;
    logic              r_rd_req;
    logic              r_desc_valid;
    sg_desc_t          r_desc;
    logic              w_rd_done;
    logic              w_last_word;

    assign w_rd_done   = (r_state == ST_FETCH_WAIT) && i_rd_rvalid;
    assign w_last_word = (r_idx == 2'(DESC_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH_REQ:  if (i_rd_gnt)    w_state_nxt = ST_FETCH_WAIT;
            ST_FETCH_WAIT: if (i_rd_rvalid) w_state_nxt = w_last_word ? ST_IDLE : ST_FETCH_REQ;
            default:       w_state_nxt = r_state;
        endcase
        if (i_fetch_go) begin
            w_state_nxt = ST_FETCH_REQ;
        end
    end

    // Request is registered from the next state so it appears one cycle after go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_idx        <= '0;
            r_rd_req     <= 1'b0;
            r_desc_valid <= 1'b0;
            r_desc       <= '0;
        end else begin
            r_rd_req     <= (w_state_nxt == ST_FETCH_REQ);
            r_desc_valid <= w_rd_done && w_last_word;
            if (i_fetch_go) begin
                r_ptr <= i_fetch_ptr;
                r_idx <= '0;
            end else if (w_rd_done && !w_last_word) begin
                r_idx <= r_idx + 2'd1;
            end
            if (w_rd_done) begin
                case (r_idx)
                    2'(DESC_SRC): r_desc.src <= i_rd_rdata;
                    2'(DESC_DST): r_desc.dst <= i_rd_rdata;
                    2'(DESC_LEN): r_desc.len <= i_rd_rdata[SG_LEN_W-1:0];
                    default: begin
                        r_desc.next <= {i_rd_rdata[ADDR_W-1:2], 2'b00};
                        r_desc.last <= i_rd_rdata[LAST_BIT];
                    end
                endcase
            end
        end
    end

    assign o_rd_req     = r_rd_req;
    assign o_rd_addr    = r_ptr + ADDR_W'({r_idx, 2'b00});
    assign o_desc_valid = r_desc_valid;
    assign o_desc       = r_desc;

endmodule

`default_nettype wire

// File: rtl/sgdmac_desc_sched.sv
// ============================================================================
// sgdmac_desc_sched
//   Walks a linked descriptor chain and issues one copy command per descriptor.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module sgdmac_desc_sched
    import sgdmac_pkg::*;
#(
    parameter  int ADDR_W   = SG_ADDR_W,
    parameter  int LEN_W    = SG_LEN_W,
    parameter  int MAX_DESC = 1024,
    localparam int CNTW     = $clog2(MAX_DESC + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_pointer_i,
    output logic              done_o,
    output logic              err_o,
    output logic [CNTW-1:0]   desc_cnt_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_gnt_i,
    input  logic              rd_rvalid_i,
    input  logic [ADDR_W-1:0] rd_rdata_i,
    output logic              xfer_req_o,
    output logic [ADDR_W-1:0] xfer_src_o,
    output logic [ADDR_W-1:0] xfer_dst_o,
    output logic [LEN_W-1:0]  xfer_len_o,
    input  logic              xfer_ack_i,
    input  logic              xfer_done_i
);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic              w_fetch_go;
    logic [ADDR_W-1:0] w_fetch_ptr;
    logic              w_desc_valid;
    sg_desc_t          w_desc;
    logic              w_step;
    logic              w_err_set;
    logic              w_start_ok;
    logic [CNTW-1:0]   r_cnt;
    logic [CNTW-1:0]   w_cnt_inc;
    logic              r_done;
    logic              r_err;
    logic              r_xfer_req;
    logic [ADDR_W-1:0] r_xfer_src;
    logic [ADDR_W-1:0] r_xfer_dst;
    logic [LEN_W-1:0]  r_xfer_len;

    sgdmac_desc_fetch #(
        .ADDR_W (ADDR_W)
    ) u_fetch (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_fetch_go   (w_fetch_go),
        .i_fetch_ptr  (w_fetch_ptr),
        .o_rd_req     (rd_req_o),
        .o_rd_addr    (rd_addr_o),
        .i_rd_gnt     (rd_gnt_i),
        .i_rd_rvalid  (rd_rvalid_i),
        .i_rd_rdata   (rd_rdata_i),
        .o_desc_valid (w_desc_valid),
        .o_desc       (w_desc)
    );

    assign w_cnt_inc = (r_cnt == CNTW'(MAX_DESC)) ? r_cnt : r_cnt + CNTW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FETCH_REQ here stands for "fetch sub-module busy" until the descriptor lands.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_go  = 1'b0;
        w_fetch_ptr = start_pointer_i;
        w_step      = 1'b0;
        w_err_set   = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_pointer_i[1:0] == 2'b00) begin
                        w_start_ok  = 1'b1;
                        w_fetch_go  = 1'b1;
                        w_state_nxt = ST_FETCH_REQ;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_FETCH_REQ: if (w_desc_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (w_desc.len == '0) begin
                    w_step = 1'b1;
                end else if (xfer_ack_i) begin
                    w_state_nxt = ST_WAIT_XFER;
                end
            end
            ST_WAIT_XFER: if (xfer_done_i) w_step = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_step) begin
            if (w_desc.last) begin
                w_state_nxt = ST_IDLE;
            end else if (w_cnt_inc == CNTW'(MAX_DESC)) begin
                w_err_set   = 1'b1;
                w_state_nxt = ST_IDLE;
            end else begin
                w_fetch_go  = 1'b1;
                w_fetch_ptr = w_desc.next;
                w_state_nxt = ST_FETCH_REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b1;
            r_err      <= 1'b0;
            r_cnt      <= '0;
            r_xfer_req <= 1'b0;
            r_xfer_src <= '0;
            r_xfer_dst <= '0;
            r_xfer_len <= '0;
        end else begin
            r_done <= (w_state_nxt == ST_IDLE);
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_start_ok) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= w_cnt_inc;
            end
            if ((r_state == ST_FETCH_REQ) && w_desc_valid) begin
                r_xfer_req <= (w_desc.len != '0);
                r_xfer_src <= w_desc.src;
                r_xfer_dst <= w_desc.dst;
                r_xfer_len <= w_desc.len;
            end else if ((r_state == ST_ISSUE) && xfer_ack_i) begin
                r_xfer_req <= 1'b0;
            end
        end
    end

    assign done_o     = r_done;
    assign err_o      = r_err;
    assign desc_cnt_o = r_cnt;
    assign xfer_req_o = r_xfer_req;
    assign xfer_src_o = r_xfer_src;
    assign xfer_dst_o = r_xfer_dst;
    assign xfer_len_o = r_xfer_len;

endmodule

`default_nettype wire

// File: tb/tb_sgdmac_desc_sched.sv
// ============================================================================
// tb_sgdmac_desc_sched
//   Directed bench: memory/engine responders, chain-walk model, cycle checker.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sgdmac_desc_sched;

    localparam int TB_MAX = 4;
    localparam int CW     = $clog2(TB_MAX + 1);

    logic        clk;
    logic        rst_n;
    logic        start_main;
    logic        start_inj;
    logic [31:0] ptr_main;
    logic        done_o;
    logic        err_o;
    logic [CW-1:0] desc_cnt_o;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_gnt_i;
    logic        rd_rvalid_i;
    logic [31:0] rd_rdata_i;
    logic        xfer_req_o;
    logic [31:0] xfer_src_o;
    logic [31:0] xfer_dst_o;
    logic [15:0] xfer_len_o;
    logic        xfer_ack_i;
    logic        xfer_done_i;

    sgdmac_desc_sched #(
        .ADDR_W   (32),
        .LEN_W    (16),
        .MAX_DESC (TB_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_main | start_inj),
        .start_pointer_i (start_inj ? 32'h0000_5002 : ptr_main),
        .done_o          (done_o),
        .err_o           (err_o),
        .desc_cnt_o      (desc_cnt_o),
        .rd_req_o        (rd_req_o),
        .rd_addr_o       (rd_addr_o),
        .rd_gnt_i        (rd_gnt_i),
        .rd_rvalid_i     (rd_rvalid_i),
        .rd_rdata_i      (rd_rdata_i),
        .xfer_req_o      (xfer_req_o),
        .xfer_src_o      (xfer_src_o),
        .xfer_dst_o      (xfer_dst_o),
        .xfer_len_o      (xfer_len_o),
        .xfer_ack_i      (xfer_ack_i),
        .xfer_done_i     (xfer_done_i)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [int unsigned];
    logic [31:0] exp_rd[$];
    logic [79:0] exp_cmd[$];
    logic [79:0] obs_cmd[$];
    int          exp_cnt;
    logic        exp_err;
    logic        model_on = 1'b0;
    int          gnt_delay = 1;
    int          ack_delay = 1;
    int          done_delay = 1;
    logic        inject = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Walk the chain as the list in memory describes it.
    function automatic void build_model(input logic [31:0] start_p);
        logic [31:0] p;
        logic [31:0] w [4];
        logic        fin;
        int          n;
        p = start_p;
        fin = 1'b0;
        n = 0;
        exp_rd.delete();
        exp_cmd.delete();
        for (int k = 0; k < TB_MAX && !fin; k++) begin
            for (int j = 0; j < 4; j++) begin
                exp_rd.push_back(p + 32'(4 * j));
                w[j] = rd_mem(p + 32'(4 * j));
            end
            if (w[2][15:0] != 16'h0) exp_cmd.push_back({w[0], w[1], w[2][15:0]});
            n++;
            if (w[3][0]) fin = 1'b1;
            else p = {w[3][31:2], 2'b00};
        end
        exp_cnt = n;
        exp_err = !fin;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory port: grant after gnt_delay cycles of request, data one cycle later.
    initial begin
        int          gwait;
        logic        pend;
        logic [31:0] paddr;
        gwait = 0;
        pend = 1'b0;
        paddr = '0;
        rd_gnt_i = 1'b0;
        rd_rvalid_i = 1'b0;
        rd_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_gnt_i = 1'b0;
            rd_rvalid_i = 1'b0;
            if (pend) begin
                rd_rvalid_i = 1'b1;
                rd_rdata_i = rd_mem(paddr);
                pend = 1'b0;
            end
            if (rd_req_o) begin
                if (gwait < gnt_delay) gwait++;
                else begin
                    rd_gnt_i = 1'b1;
                    gwait = 0;
                    pend = 1'b1;
                    paddr = rd_addr_o;
                end
            end
        end
    end

    // Copy engine: ack after ack_delay cycles, done pulse done_delay cycles after ack.
    initial begin
        int await;
        int dcd;
        await = 0;
        dcd = 0;
        xfer_ack_i = 1'b0;
        xfer_done_i = 1'b0;
        start_inj = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            xfer_ack_i = 1'b0;
            xfer_done_i = 1'b0;
            start_inj = 1'b0;
            if (dcd > 0) begin
                dcd--;
                if (dcd == 0) xfer_done_i = 1'b1;
            end
            if (xfer_req_o) begin
                if (await < ack_delay) begin
                    await++;
                    if (inject && await > 1) begin
                        start_inj = 1'b1;
                        inject = 1'b0;
                    end
                end else begin
                    xfer_ack_i = 1'b1;
                    await = 0;
                    dcd = done_delay;
                end
            end
        end
    end

    // Per-cycle compare against the model queues plus handshake stability.
    initial begin
        logic        p_rreq, p_rgnt, p_xreq, p_xack;
        logic [31:0] p_raddr;
        logic [79:0] p_cmd;
        p_rreq = 0; p_rgnt = 0; p_xreq = 0; p_xack = 0; p_raddr = '0; p_cmd = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (p_rreq && !p_rgnt) begin
                    check("rd_hold_req", rd_req_o, 1'b1);
                    check("rd_hold_addr", rd_addr_o, p_raddr);
                end
                if (p_xreq && !p_xack) begin
                    check("xfer_hold_req", xfer_req_o, 1'b1);
                    check("xfer_hold_cmd", {xfer_src_o, xfer_dst_o, xfer_len_o}, p_cmd);
                end
                if (model_on && rd_req_o && rd_gnt_i) begin
                    if (exp_rd.size() == 0) check("rd_extra", rd_addr_o, 96'hFFFF_FFFF_FFFF);
                    else check("rd_addr", rd_addr_o, exp_rd.pop_front());
                end
                if (model_on && xfer_req_o && xfer_ack_i) begin
                    obs_cmd.push_back({xfer_src_o, xfer_dst_o, xfer_len_o});
                    if (exp_cmd.size() == 0) check("xfer_extra", {xfer_src_o, xfer_dst_o, xfer_len_o}, 96'hFFFF_FFFF_FFFF);
                    else check("xfer_cmd", {xfer_src_o, xfer_dst_o, xfer_len_o}, exp_cmd.pop_front());
                end
            end
            p_rreq = rd_req_o; p_rgnt = rd_gnt_i; p_raddr = rd_addr_o;
            p_xreq = xfer_req_o; p_xack = xfer_ack_i; p_cmd = {xfer_src_o, xfer_dst_o, xfer_len_o};
        end
    end

    task automatic pulse_start(input logic [31:0] p);
        @(posedge clk);
        #1;
        start_main = 1'b1;
        ptr_main = p;
        @(posedge clk);
        #1;
        start_main = 1'b0;
    endtask

    task automatic run_chain(input logic [31:0] p, input int gd, input int ad, input int dd);
        int cyc;
        gnt_delay = gd;
        ack_delay = ad;
        done_delay = dd;
        build_model(p);
        obs_cmd.delete();
        model_on = 1'b1;
        pulse_start(p);
        @(negedge clk);
        check("done_drop", done_o, 1'b0);
        cyc = 0;
        while (!done_o && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("chain_timeout", cyc < 2000, 1'b1);
        check("chain_cnt", desc_cnt_o, exp_cnt);
        check("chain_err", err_o, exp_err);
        check("rd_left", exp_rd.size(), 0);
        check("cmd_left", exp_cmd.size(), 0);
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start_main = 1'b0;
        ptr_main = '0;

        // Single descriptor, plus the chain used by later tests.
        mem[32'h1000] = 32'h2000; mem[32'h1004] = 32'h3000;
        mem[32'h1008] = 32'd64;   mem[32'h100C] = 32'h0000_0001;
        mem[32'h1100] = 32'h2100; mem[32'h1104] = 32'h3100;
        mem[32'h1108] = 32'd128;  mem[32'h110C] = 32'h0000_1202;
        mem[32'h1200] = 32'h2200; mem[32'h1204] = 32'h3200;
        mem[32'h1208] = 32'hABCD_0020; mem[32'h120C] = 32'h0000_0001;
        mem[32'h2000] = 32'hA000; mem[32'h2004] = 32'hB000;
        mem[32'h2008] = 32'd16;   mem[32'h200C] = 32'h0000_2000;

        repeat (3) @(negedge clk);
        check("rst_done", done_o, 1'b1);
        check("rst_err", err_o, 1'b0);
        check("rst_cnt", desc_cnt_o, 0);
        check("rst_rd_req", rd_req_o, 1'b0);
        check("rst_xfer_req", xfer_req_o, 1'b0);
        check("rst_outs", {rd_addr_o, xfer_src_o, xfer_dst_o}, 96'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_chain(32'h1000, 1, 1, 1);
        check("t1_ncmd", obs_cmd.size(), 1);
        check("t1_cmd", obs_cmd.size() > 0 ? obs_cmd[0] : 80'h0, {32'h2000, 32'h3000, 16'd64});
        check("t1_cnt", desc_cnt_o, 1);

        mem[32'h100C] = 32'h0000_1100;
        mem[32'h1208] = 32'd32;
        run_chain(32'h1000, 1, 1, 1);
        check("t2_ncmd", obs_cmd.size(), 3);
        check("t2_cmd2", obs_cmd.size() > 2 ? obs_cmd[2] : 80'h0, {32'h2200, 32'h3200, 16'd32});
        check("t2_cnt", desc_cnt_o, 3);

        mem[32'h1108] = 32'hABCD_0000;
        run_chain(32'h1000, 0, 2, 3);
        check("t3_ncmd", obs_cmd.size(), 2);
        check("t3_cnt", desc_cnt_o, 3);

        mem[32'h100C] = 32'h0000_0001;
        inject = 1'b1;
        run_chain(32'h1000, 5, 5, 2);
        check("t4_inject_used", inject, 1'b0);
        check("t4_err", err_o, 1'b0);
        check("t4_cnt", desc_cnt_o, 1);

        // Misaligned start pointer: error, no fetch, counter untouched.
        model_on = 1'b1;
        exp_rd.delete();
        exp_cmd.delete();
        pulse_start(32'h0000_1002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bad_no_req", rd_req_o, 1'b0);
        end
        check("bad_err", err_o, 1'b1);
        check("bad_done", done_o, 1'b1);
        check("bad_cnt", desc_cnt_o, 1);

        run_chain(32'h2000, 1, 1, 1);
        check("loop_ncmd", obs_cmd.size(), 4);
        check("loop_err", err_o, 1'b1);
        check("loop_done", done_o, 1'b1);
        check("loop_cnt", desc_cnt_o, 4);

        // Reset while the engine is busy; its late done must be ignored.
        model_on = 1'b0;
        done_delay = 40;
        ack_delay = 1;
        gnt_delay = 1;
        pulse_start(32'h1000);
        cyc = 0;
        while (!(xfer_req_o && xfer_ack_i) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("mr_ack_seen", cyc < 200, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_done", done_o, 1'b1);
        check("mr_err_cnt", {err_o, desc_cnt_o}, 0);
        check("mr_reqs", {rd_req_o, xfer_req_o}, 0);
        check("mr_outs", {rd_addr_o, xfer_src_o, xfer_len_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("mr_late_cnt", desc_cnt_o, 0);
        check("mr_idle", {done_o, xfer_req_o, rd_req_o}, 3'b100);

        run_chain(32'h1000, 1, 1, 1);
        check("mr_restart_cnt", desc_cnt_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
